// File: rtl/alu_cmd_queue.sv
// Command FIFO and issue stage in front of the 8-bit ALU; the ALU result is registered toward downstream.
// Optional result flags (res_zero, res_neg) are enabled by defining ALU_CMD_QUEUE_FLAGS_EN.
module alu_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_oper,
    input  logic [7:0]    cmd_a,
    input  logic [7:0]    cmd_b,
    input  logic          cmd_c_in,
    output logic [2:0]    alu_oper,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic          alu_c_in,
    input  logic [7:0]    alu_sum,
    input  logic          alu_c_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [7:0]    res_sum,
    output logic          res_c_out,
    output logic [AW:0]   count
`ifdef ALU_CMD_QUEUE_FLAGS_EN
    ,
    output logic          res_zero,
    output logic          res_neg
`endif
);

    localparam int            EW       = 20;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] head;
    logic          has_data;
    logic          push;
    logic          pop;

    assign has_data  = (count != '0);
    assign cmd_ready = (count != CNT_FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = has_data && (!res_valid || res_ready);
    assign head      = mem[rd_ptr];

    // Empty queue presents zeros so the ALU sees a quiet input.
    assign {alu_oper, alu_a, alu_b, alu_c_in} = has_data ? head : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_oper, cmd_a, cmd_b, cmd_c_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // The popped head is on the ALU inputs this cycle, so its result is captured as it leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_c_out <= 1'b0;
        end else if (pop) begin
            res_valid <= 1'b1;
            res_sum   <= alu_sum;
            res_c_out <= alu_c_out;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef ALU_CMD_QUEUE_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_zero <= 1'b0;
            res_neg  <= 1'b0;
        end else if (pop) begin
            res_zero <= (alu_sum == 8'h00);
            res_neg  <= alu_sum[7];
        end
    end
`endif

endmodule
